dp_operand_sequencer: RTL
=========================

# dp_operand_sequencer

Multi-cycle operand sequencer for the data-processing execute stage. It accepts one ARM data-processing instruction at a time and reads Rn, Rm and Rs in order from a single registered register-file read port. It decodes and drives the shifter mode (`opState`) and operands into the `src2shift` operand-2 shifter, then latches `src2`/carry and presents a complete operand bundle to the ALU over a valid/ready handshake.

## Interface
- No parameters; all widths are fixed by the ARM data-processing format.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `instr_valid` in 1: instruction offered.
- `instr` in 32: data-processing instruction; cond bits [31:28] are ignored.
- `instr_ready` out 1: high exactly when the state is IDLE.
- `rf_rd_en` out 1: register-file read strobe.
- `rf_rd_addr` out 4: read address.
- `rf_rd_data` in 32: read data, valid the cycle after `rf_rd_en`.
- `sh_rs` out 32: Rs operand to the shifter, held from a latch.
- `sh_rm` out 32: Rm operand to the shifter, held from a latch.
- `sh_imm24` out 24: latched `instr[23:0]`.
- `sh_opstate` out 4: latched shifter mode.
- `sh_src2` in 32: shifter result.
- `sh_c` in 1: shifter carry-out.
- `out_valid` out 1: operand bundle valid.
- `out_ready` in 1: ALU accepts the bundle.
- `out_rn` out 32: latched Rn value.
- `out_src2` out 32: latched operand 2.
- `out_c` out 1: latched shifter carry.
- `out_rd` out 4: destination register.
- `out_opcode` out 4: ALU opcode.
- `out_s` out 1: set-flags bit.

## Operation
- **Decode at accept:**
  - Fields: I=`instr[25]`, opcode=`instr[24:21]`, S=`instr[20]`, Rn=`[19:16]`, Rd=`[15:12]`, Rs=`[11:8]`, Rm=`[3:0]`.
  - `sh_opstate`: I=1 → 0 (rotated immediate); I=0 and `instr[4]`=0 → 1+`instr[6:5]` (LSL/LSR/ASR/ROR by shamt5, values 1..4); I=0 and `instr[4]`=1 → 5+`instr[6:5]` (by register, values 5..8). Values 9..15 are never driven.
  - no_rn = opcode 1101 (MOV) or 1111 (MVN). When no_rn is set, Rn is not read and `out_rn`=0.
- **States:** IDLE, RD_RN, RD_RM, RD_RS, LAST, SHIFT, OUT.
- **Transitions:**
  - IDLE: on `instr_valid`, latch the instruction and go to the first required read. The first read is RD_RN if !no_rn; else RD_RM if I=0; else SHIFT.
  - RD_RN: to RD_RM if I=0, else to LAST.
  - RD_RM: to RD_RS if register-shift, else to LAST.
  - RD_RS: to LAST.
  - LAST: to SHIFT.
  - SHIFT: to OUT.
  - OUT: to IDLE when `out_ready`.
- **Reads:**
  - RD_xx asserts `rf_rd_en` with the matching address.
  - A 2-bit pending tag records which latch (Rn/Rm/Rs/none) receives `rf_rd_data` on the following edge.
  - Capture happens in the state after each issue, including LAST.
  - Reads are issued strictly in Rn, Rm, Rs order.
  - `rf_rd_en` is 0 in IDLE, LAST, SHIFT and OUT.
- **Shifter drive:** `sh_rm`, `sh_rs`, `sh_imm24` and `sh_opstate` come straight from latches, so they are stable from accept through OUT. Unread operands are held at 0.
- **SHIFT:** latch `sh_src2` into `out_src2` and `sh_c` into `out_c`.
- **OUT:**
  - Holds `out_valid`=1; all `out_*` signals are stable until the handshake.
  - Only one instruction is in flight; no new accept occurs in the cycle of the `out_ready` handshake.
- **Reset (at any state, including mid-read):** next state IDLE with:
  - `out_valid`=0, `rf_rd_en`=0, `rf_rd_addr`=0.
  - All latches 0, `sh_opstate`=0, pending tag = none.
  - `instr_ready`=1 from the first cycle after reset deasserts.
  - A pending read's returning data is discarded.

## Timing
- Latency is counted from the accept edge to the first cycle with `out_valid`=1:
  - I=1 with no_rn: 2.
  - I=1 otherwise: 4.
  - Shift by immediate: 5 (4 if no_rn).
  - Shift by register: 6 (5 if no_rn).
- Throughput is one instruction per latency+1 cycles at best, because of the mandatory IDLE cycle after the OUT handshake.
- `out_ready` held low: OUT persists indefinitely; outputs hold, no reads are issued, `instr_ready`=0.
- `instr_valid` outside IDLE is ignored. The instruction is not latched and no state changes.

## Test plan
- **MOV immediate:** `0xE3A01285` (MOV R1,#0x85 ror 4) → `sh_opstate`=0, no `rf_rd_en` pulses, `out_valid` 2 cycles after accept, `out_src2`=`0x50000008`, `out_rd`=1, `out_rn`=0.
- **Shift by immediate:** `0xE0810282` (ADD R0,R1,R2 LSL #5) with R1=1, R2=2 → `sh_opstate`=1, reads addr 1 then 2 on consecutive cycles, `out_valid` at cycle 5, `out_rn`=1, `out_src2`=`0x40`, `out_c`=0, `out_opcode`=`0100`.
- **Shift by register:** `0xE0810332` (ADD R0,R1,R2 LSR R3) with R3=4 → `sh_opstate`=6, reads 1,2,3, `sh_rs`=4, `out_valid` at cycle 6, `out_src2`=0.
- **Backpressure:** `out_ready`=0 for 10 cycles in OUT → all `out_*` stable, `instr_ready`=0, `rf_rd_en`=0. Then `out_ready`=1 → IDLE next cycle, and the next instruction is accepted the cycle after.
- **Reset mid-operation:** reset asserted one cycle during RD_RM of the register-shift case → next cycle IDLE, `out_valid`=0, `rf_rd_en`=0, latches 0. A subsequent ADD completes with correct values and no stale Rn.
- **Back-to-back instructions:** three instructions offered with `instr_valid` held high and `out_ready`=1 → each result appears in order with the per-case latencies above and exactly one IDLE cycle between bundles.

Source files
------------

// File: rtl/dp_operand_sequencer.sv
// Multi-cycle operand sequencer for the data-processing execute stage: reads Rn/Rm/Rs
// through one registered register-file port, drives the operand-2 shifter and hands a bundle to the ALU.
module dp_operand_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    output logic        rf_rd_en,
    output logic [3:0]  rf_rd_addr,
    input  logic [31:0] rf_rd_data,
    output logic [31:0] sh_rs,
    output logic [31:0] sh_rm,
    output logic [23:0] sh_imm24,
    output logic [3:0]  sh_opstate,
    input  logic [31:0] sh_src2,
    input  logic        sh_c,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rn,
    output logic [31:0] out_src2,
    output logic        out_c,
    output logic [3:0]  out_rd,
    output logic [3:0]  out_opcode,
    output logic        out_s
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_RN,
        ST_RD_RM,
        ST_RD_RS,
        ST_LAST,
        ST_SHIFT,
        ST_OUT
    } state_t;

    // Which operand latch the read data arriving on the next edge belongs to.
    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_RN,
        TAG_RM,
        TAG_RS
    } tag_t;

    state_t      state;
    state_t      state_nxt;
    tag_t        pending;
    tag_t        issue_tag;
    logic        accept;

    logic        i_q;
    logic [3:0]  opcode_q;
    logic [23:0] imm24_q;
    logic [3:0]  opstate_q;
    logic [31:0] rn_q;
    logic [31:0] rm_q;
    logic [31:0] rs_q;
    logic [31:0] src2_q;
    logic        c_q;

    logic        in_no_rn;
    logic [3:0]  in_opstate;
    logic        reg_shift_q;
    logic        unused_instr_bits;

    // Condition code and format bits play no part in operand sequencing.
    assign unused_instr_bits = ^instr[31:26];

    assign in_no_rn    = (instr[24:21] == 4'b1101) || (instr[24:21] == 4'b1111);
    assign in_opstate  = instr[25] ? 4'd0 :
                         instr[4]  ? 4'd5 + {2'b00, instr[6:5]} :
                                     4'd1 + {2'b00, instr[6:5]};
    assign reg_shift_q = ~i_q & imm24_q[4];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        rf_rd_en   = 1'b0;
        rf_rd_addr = 4'd0;
        issue_tag  = TAG_NONE;
        unique case (state)
            ST_IDLE: begin
                if (instr_valid) begin
                    accept = 1'b1;
                    if (!in_no_rn) begin
                        state_nxt = ST_RD_RN;
                    end else if (!instr[25]) begin
                        state_nxt = ST_RD_RM;
                    end else begin
                        state_nxt = ST_SHIFT;
                    end
                end
            end
            ST_RD_RN: begin
                rf_rd_en   = 1'b1;
                rf_rd_addr = imm24_q[19:16];
                issue_tag  = TAG_RN;
                state_nxt  = i_q ? ST_LAST : ST_RD_RM;
            end
            ST_RD_RM: begin
                rf_rd_en   = 1'b1;
                rf_rd_addr = imm24_q[3:0];
                issue_tag  = TAG_RM;
                state_nxt  = reg_shift_q ? ST_RD_RS : ST_LAST;
            end
            ST_RD_RS: begin
                rf_rd_en   = 1'b1;
                rf_rd_addr = imm24_q[11:8];
                issue_tag  = TAG_RS;
                state_nxt  = ST_LAST;
            end
            ST_LAST:  state_nxt = ST_SHIFT;
            ST_SHIFT: state_nxt = ST_OUT;
            ST_OUT: begin
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: operand latches are cleared on reset so a read in flight at reset can never leak into a later bundle.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending   <= TAG_NONE;
            i_q       <= 1'b0;
            opcode_q  <= 4'd0;
            imm24_q   <= 24'd0;
            opstate_q <= 4'd0;
            rn_q      <= 32'd0;
            rm_q      <= 32'd0;
            rs_q      <= 32'd0;
            src2_q    <= 32'd0;
            c_q       <= 1'b0;
        end else begin
            pending <= issue_tag;
            unique case (pending)
                TAG_RN:  rn_q <= rf_rd_data;
                TAG_RM:  rm_q <= rf_rd_data;
                TAG_RS:  rs_q <= rf_rd_data;
                default: ;
            endcase

            // Operands that will not be read stay at zero for the whole instruction.
            if (accept) begin
                i_q       <= instr[25];
                opcode_q  <= instr[24:21];
                imm24_q   <= instr[23:0];
                opstate_q <= in_opstate;
                rn_q      <= 32'd0;
                rm_q      <= 32'd0;
                rs_q      <= 32'd0;
                src2_q    <= 32'd0;
                c_q       <= 1'b0;
            end

            if (state == ST_SHIFT) begin
                src2_q <= sh_src2;
                c_q    <= sh_c;
            end
        end
    end

    assign instr_ready = (state == ST_IDLE);
    assign out_valid   = (state == ST_OUT);

    assign sh_rs       = rs_q;
    assign sh_rm       = rm_q;
    assign sh_imm24    = imm24_q;
    assign sh_opstate  = opstate_q;

    assign out_rn      = rn_q;
    assign out_src2    = src2_q;
    assign out_c       = c_q;
    assign out_rd      = imm24_q[15:12];
    assign out_opcode  = opcode_q;
    assign out_s       = imm24_q[20];

endmodule
